tpsram_param_clr: RTL and testbench

Parametrised two-port synchronous SRAM and the successor to the fixed 8x64 TPSRAM. It has one write port and one read port on a single clock, and width and depth are set by parameters. It adds a post-reset clear sweep, an optional output pipeline stage, a read-valid strobe and a selectable read-during-write collision policy. It sits behind MSS/fabric buffering logic, for example ISP page buffers, where deterministic contents after reset are required.

---
 rtl/tpsram_pkg.sv | 33 +++
 rtl/tpsram_core.sv | 37 +++
 rtl/tpsram_param_clr.sv | 162 ++++++++++++++++
 tb/tb_tpsram_param_clr.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpsram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpsram_pkg
// Desc     : Shared types, legal parameter values and helpers for tpsram_param_clr
// Revision : 1.0
// ============================================================================
package tpsram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Source of the data presented on the read port after an accepted read
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_WD   = 2'd2,
        SEL_INIT = 2'd3
    } rd_sel_t;

    localparam int c_RD_PIPE_1CYC = 0;
    localparam int c_RD_PIPE_2CYC = 1;
    localparam int c_BYPASS_OLD   = 0;
    localparam int c_BYPASS_NEW   = 1;

    // One extra bit lets the sweep reach DEPTH == 2**ADDR_WIDTH without wrapping
    function automatic int clr_cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpsram_core.sv
`default_nettype none
// ============================================================================
// Module   : tpsram_core
// Desc     : Reset-free storage array, one write port and one registered read port
// Revision : 1.0
// ============================================================================
module tpsram_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read-first: a same-edge write is not visible to the read
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tpsram_param_clr.sv
`default_nettype none
// ============================================================================
// Module   : tpsram_param_clr
// Desc     : Parametrised two-port SRAM with post-reset clear sweep and read pipeline
// Revision : 1.0
// ============================================================================
module tpsram_param_clr
    import tpsram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DEPTH      = 64,
    parameter int                    RD_PIPE    = 0,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    input  logic                  REN,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  RD_VALID,
    output logic                  INIT_DONE
);

    localparam int                 c_CNT_W = clr_cnt_width(ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_clr_cnt;
    logic                  r_init_done;

    logic                  r_s1_valid;
    rd_sel_t               r_s1_sel;
    logic [DATA_WIDTH-1:0] r_s1_wd;
    logic [DATA_WIDTH-1:0] w_s1_data;

    logic                  w_wr_ok;
    logic                  w_rd_acc;
    logic                  w_rd_in;
    logic                  w_collide;
    logic                  w_clearing;
    logic                  w_core_we;
    logic                  w_core_re;
    logic [ADDR_WIDTH-1:0] w_core_waddr;
    logic [DATA_WIDTH-1:0] w_core_wdata;
    logic [DATA_WIDTH-1:0] w_core_rdata;

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_wr_ok    = WEN & r_init_done & ({1'b0, WADDR} < c_DEPTH);
    assign w_rd_acc   = REN & r_init_done;
    assign w_rd_in    = ({1'b0, RADDR} < c_DEPTH);
    assign w_collide  = w_wr_ok & w_rd_in & (WADDR == RADDR);

    // The sweep owns the write port until it completes
    assign w_core_we    = ~RESET & (w_clearing | w_wr_ok);
    assign w_core_waddr = w_clearing ? r_clr_cnt[ADDR_WIDTH-1:0] : WADDR;
    assign w_core_wdata = w_clearing ? INIT_VALUE : WD;
    assign w_core_re    = ~RESET & w_rd_acc & w_rd_in;

    tpsram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk     (CLK),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_core_re),
        .i_raddr (RADDR),
        .o_rdata (w_core_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + c_CNT_W'(1);
                    if (r_clr_cnt == c_LAST) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Selection only moves on an accepted read so the output holds between reads
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= SEL_ZERO;
            r_s1_wd    <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_wd <= WD;
                if (!w_rd_in) begin
                    r_s1_sel <= SEL_INIT;
                end else if ((BYPASS == c_BYPASS_NEW) && w_collide) begin
                    r_s1_sel <= SEL_WD;
                end else begin
                    r_s1_sel <= SEL_MEM;
                end
            end
        end
    end

    always_comb begin
        w_s1_data = '0;
        case (r_s1_sel)
            SEL_ZERO: w_s1_data = '0;
            SEL_MEM:  w_s1_data = w_core_rdata;
            SEL_WD:   w_s1_data = r_s1_wd;
            SEL_INIT: w_s1_data = INIT_VALUE;
            default:  w_s1_data = '0;
        endcase
    end

    generate
        if (RD_PIPE == c_RD_PIPE_2CYC) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_rd;
            logic                  r_rd_valid;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_rd       <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_rd <= w_s1_data;
                    end
                end
            end

            assign RD       = r_rd;
            assign RD_VALID = r_rd_valid;
        end else begin : g_no_out_reg
            assign RD       = w_s1_data;
            assign RD_VALID = r_s1_valid;
        end
    endgenerate

    assign INIT_DONE = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_tpsram_param_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpsram_param_clr
// Desc     : Scoreboard bench driving a 1-cycle/bypass and a 2-cycle/old-data instance
// Revision : 1.0
// ============================================================================
module tb_tpsram_param_clr;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [17:0] WD = '0;
    logic [5:0]  WADDR = '0;
    logic [5:0]  RADDR = '0;
    logic        WEN = 1'b0;
    logic        REN = 1'b0;

    logic [7:0]  rd_a;
    logic        rd_valid_a, init_done_a;
    logic [17:0] rd_b;
    logic        rd_valid_b, init_done_b;

    always #5 CLK = ~CLK;

    tpsram_param_clr #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .DEPTH      (64),
        .RD_PIPE    (0),
        .BYPASS     (1),
        .INIT_VALUE (8'h00)
    ) dut_a (
        .CLK       (CLK),
        .RESET     (RESET),
        .WD        (WD[7:0]),
        .WADDR     (WADDR),
        .WEN       (WEN),
        .RADDR     (RADDR),
        .REN       (REN),
        .RD        (rd_a),
        .RD_VALID  (rd_valid_a),
        .INIT_DONE (init_done_a)
    );

    tpsram_param_clr #(
        .DATA_WIDTH (18),
        .ADDR_WIDTH (6),
        .DEPTH      (48),
        .RD_PIPE    (1),
        .BYPASS     (0),
        .INIT_VALUE (18'h0003C)
    ) dut_b (
        .CLK       (CLK),
        .RESET     (RESET),
        .WD        (WD),
        .WADDR     (WADDR),
        .WEN       (WEN),
        .RADDR     (RADDR),
        .REN       (REN),
        .RD        (rd_b),
        .RD_VALID  (rd_valid_b),
        .INIT_DONE (init_done_b)
    );

    typedef struct {
        int          due;
        logic [17:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  ma [0:63];
    logic [17:0] mb [0:47];
    int          m_cnt_a, m_cnt_b;
    logic        m_done_a, m_done_b;
    logic [7:0]  m_rd_a;
    logic [17:0] m_rd_b;
    int          cyc_n = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Drive one edge, predict both instances, then score what they produce
    task automatic cyc(input logic rst, input logic wen, input logic [5:0] wa,
                       input logic [17:0] wd, input logic ren, input logic [5:0] ra);
        exp_t e;
        logic ev;
        RESET = rst; WEN = wen; WADDR = wa; WD = wd; REN = ren; RADDR = ra;

        if (rst) begin
            m_done_a = 1'b0; m_cnt_a = 0; qa.delete(); m_rd_a = '0;
        end else if (!m_done_a) begin
            ma[m_cnt_a] = 8'h00;
            if (m_cnt_a == 63) m_done_a = 1'b1;
            m_cnt_a++;
        end else begin
            if (ren) begin
                e.due  = cyc_n + 1;
                e.data = {10'b0, (wen && wa == ra) ? wd[7:0] : ma[ra]};
                qa.push_back(e);
            end
            if (wen) ma[wa] = wd[7:0];
        end

        if (rst) begin
            m_done_b = 1'b0; m_cnt_b = 0; qb.delete(); m_rd_b = '0;
        end else if (!m_done_b) begin
            mb[m_cnt_b] = 18'h0003C;
            if (m_cnt_b == 47) m_done_b = 1'b1;
            m_cnt_b++;
        end else begin
            if (ren) begin
                e.due  = cyc_n + 2;
                e.data = (ra >= 6'd48) ? 18'h0003C : mb[ra];
                qb.push_back(e);
            end
            if (wen && wa < 6'd48) mb[wa] = wd;
        end

        @(posedge CLK);
        #1;
        cyc_n++;

        ev = 1'b0;
        if (qa.size() > 0) ev = (qa[0].due == cyc_n);
        if (ev) begin e = qa.pop_front(); m_rd_a = e.data[7:0]; end
        n_vec++;
        if (rd_valid_a !== ev) begin
            n_err++; $display("FAIL a.rd_valid cycle %0d: got %b want %b", cyc_n, rd_valid_a, ev);
        end
        n_vec++;
        if (rd_a !== m_rd_a) begin
            n_err++; $display("FAIL a.rd cycle %0d: got %h want %h", cyc_n, rd_a, m_rd_a);
        end
        n_vec++;
        if (init_done_a !== m_done_a) begin
            n_err++; $display("FAIL a.init_done cycle %0d: got %b want %b", cyc_n, init_done_a, m_done_a);
        end

        ev = 1'b0;
        if (qb.size() > 0) ev = (qb[0].due == cyc_n);
        if (ev) begin e = qb.pop_front(); m_rd_b = e.data; end
        n_vec++;
        if (rd_valid_b !== ev) begin
            n_err++; $display("FAIL b.rd_valid cycle %0d: got %b want %b", cyc_n, rd_valid_b, ev);
        end
        n_vec++;
        if (rd_b !== m_rd_b) begin
            n_err++; $display("FAIL b.rd cycle %0d: got %h want %h", cyc_n, rd_b, m_rd_b);
        end
        n_vec++;
        if (init_done_b !== m_done_b) begin
            n_err++; $display("FAIL b.init_done cycle %0d: got %b want %b", cyc_n, init_done_b, m_done_b);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc(1'b1, 1'b1, 6'd1, 18'h3FFFF, 1'b1, 6'd1);
        n_vec++;
        if (rd_a !== 8'h00 || rd_valid_a !== 1'b0 || init_done_a !== 1'b0) begin
            n_err++; $display("FAIL reset_a: got rd=%h v=%b d=%b want 00/0/0", rd_a, rd_valid_a, init_done_a);
        end
        n_vec++;
        if (rd_b !== 18'h0 || rd_valid_b !== 1'b0 || init_done_b !== 1'b0) begin
            n_err++; $display("FAIL reset_b: got rd=%h v=%b d=%b want 0/0/0", rd_b, rd_valid_b, init_done_b);
        end
    endtask

    task automatic test_clear_sweep();
        int ea = -1;
        int eb = -1;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0, !m_done_b, 6'($urandom), 18'($urandom), 1'b1, 6'($urandom));
            if (init_done_b && eb < 0) eb = i;
            if (init_done_a && ea < 0) ea = i;
            if (init_done_a) break;
        end
        n_vec++;
        if (ea != 64) begin
            n_err++; $display("FAIL sweep_len_a: got %0d edges want 64", ea);
        end
        n_vec++;
        if (eb != 48) begin
            n_err++; $display("FAIL sweep_len_b: got %0d edges want 48", eb);
        end
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'(i));
        repeat (2) cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
    endtask

    task automatic test_latency();
        cyc(1'b0, 1'b1, 6'd5, 18'h000A5, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'd5);
        n_vec++;
        if (rd_valid_a !== 1'b1 || rd_a !== 8'hA5 || rd_valid_b !== 1'b0) begin
            n_err++; $display("FAIL latency_1: got a=%h/%b b.v=%b want A5/1/0", rd_a, rd_valid_a, rd_valid_b);
        end
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
        n_vec++;
        if (rd_valid_b !== 1'b1 || rd_b !== 18'h000A5 || rd_valid_a !== 1'b0) begin
            n_err++; $display("FAIL latency_2: got b=%h/%b a.v=%b want A5/1/0", rd_b, rd_valid_b, rd_valid_a);
        end
    endtask

    task automatic test_collision();
        cyc(1'b0, 1'b1, 6'd9, 18'h00011, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 6'd9, 18'h00022, 1'b1, 6'd9);
        n_vec++;
        if (rd_a !== 8'h22) begin
            n_err++; $display("FAIL collide_bypass: got %h want 22", rd_a);
        end
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'd9);
        n_vec++;
        if (rd_b !== 18'h00011) begin
            n_err++; $display("FAIL collide_old: got %h want 11", rd_b);
        end
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
        n_vec++;
        if (rd_b !== 18'h00022 || rd_a !== 8'h22) begin
            n_err++; $display("FAIL collide_after: got a=%h b=%h want 22/22", rd_a, rd_b);
        end
    endtask

    task automatic test_out_of_range();
        cyc(1'b0, 1'b1, 6'd50, 18'h000FF, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 6'd47, 18'h21234, 1'b1, 6'd50);
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'd47);
        n_vec++;
        if (rd_valid_b !== 1'b1 || rd_b !== 18'h0003C) begin
            n_err++; $display("FAIL oor_read: got %h/%b want 3C/1", rd_b, rd_valid_b);
        end
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
        n_vec++;
        if (rd_b !== 18'h21234) begin
            n_err++; $display("FAIL last_word: got %h want 21234", rd_b);
        end
    endtask

    task automatic test_pipe_hazard();
        cyc(1'b0, 1'b1, 6'd7, 18'h000AA, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'd7);
        cyc(1'b0, 1'b1, 6'd7, 18'h00155, 1'b0, 6'd0);
        n_vec++;
        if (rd_valid_b !== 1'b1 || rd_b !== 18'h000AA) begin
            n_err++; $display("FAIL pipe_hazard: got %h/%b want AA/1", rd_b, rd_valid_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] wa;
        for (int i = 0; i < 400; i++) begin
            wa = 6'($urandom);
            cyc(1'b0, 1'($urandom), wa, 18'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? wa : 6'($urandom));
        end
        repeat (3) cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++; $display("FAIL drain: got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int ea = -1;
        cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'd7);
        cyc(1'b1, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
        n_vec++;
        if (rd_valid_b !== 1'b0 || rd_b !== 18'h0 || init_done_b !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got %h/%b/%b want 0/0/0", rd_b, rd_valid_b, init_done_b);
        end
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b1, 6'($urandom));
            if (init_done_a) begin ea = i; break; end
        end
        n_vec++;
        if (ea != 64) begin
            n_err++; $display("FAIL resweep_len: got %0d edges want 64", ea);
        end
        repeat (3) cyc(1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 6'd0);
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_latency();
        test_collision();
        test_out_of_range();
        test_pipe_hazard();
        test_back_to_back();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
